prio_mem_arbiter: RTL
=====================

Name: prio_mem_arbiter

Overview:
N-to-1 memory request arbiter with in-order response routing. It is the parametrised successor of the fixed 2-port arbiter used by the CPU top level. Adds a selectable fixed-priority or round-robin policy, an anti-starvation limit, and grant locking. It sits between the CPU's fetch/execute memory ports (the data port is master 0, the privileged one) and the single external decoupled memory interface.

Parameters:
CNT, 2, number of master ports (≥1)
QUEUE_DEPTH, 2, outstanding-request tracking depth (≥1)
PRIO_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
STARVE_LIMIT, 4, fixed mode only: consecutive lost arbitrations before a master is promoted; 0 disables

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
master_req[CNT]  decoupled.in  mreq  per-master request channels
master_resp[CNT]  decoupled.out  mtrans  per-master response channels
slave_req  decoupled.out  mreq  merged request to memory
slave_resp  decoupled.in  mtrans  memory responses, strictly in issue order

Behaviour:
- Reset (async, immediate):
  - ID queue empty; RR pointer = 0; lock cleared; all starve counters = 0.
  - slave_req.valid = 0; every master_resp.valid = 0; every master_req.ready = 0; slave_resp.ready = 0.
- Grant selection (combinational, when not locked), among masters with valid = 1:
  - PRIO_MODE 0: any master whose starve counter has reached STARVE_LIMIT wins, lowest such index first. Otherwise the lowest valid index wins.
  - PRIO_MODE 1: first valid index at or after the RR pointer, wrapping modulo CNT.
- Issue gating:
  - can_issue = (count < QUEUE_DEPTH) OR (slave_resp handshake this cycle).
  - Dequeue and enqueue in the same cycle while full is allowed. This creates a combinational path from slave_resp.valid to slave_req.valid, which is accepted.
- Request forwarding:
  - slave_req.valid = granted master's valid AND can_issue.
  - slave_req.data = granted master's data.
  - Granted master's ready = slave_req.ready AND can_issue; all other masters' ready = 0.
- Lock:
  - If slave_req.valid = 1 and slave_req.ready = 0, the grant index is registered and held until the handshake completes.
  - While locked, no re-arbitration occurs, even if a higher-priority or promoted master raises valid.
- On request handshake:
  - Push granted index into the ID FIFO.
  - RR mode: pointer ← (granted + 1) mod CNT.
  - Fixed mode: granted master's counter ← 0; each other master that was valid has its counter incremented, saturating at STARVE_LIMIT. Counters of non-valid masters are unchanged.
- Response routing:
  - Head index h of the ID FIFO selects the master.
  - master_resp[h].valid = slave_resp.valid AND FIFO non-empty; master_resp[h].data = slave_resp.data.
  - slave_resp.ready = master_resp[h].ready AND FIFO non-empty.
  - On handshake, pop the FIFO.
- Empty FIFO: slave_resp.ready = 0. A response arriving while empty is a protocol violation, flagged by a simulation assertion; no master sees it.
- Latency: 0 cycles request-to-slave and response-to-master (pure pass-through); 1 cycle for a state update.
- FIFO: circular buffer, pointer width $clog2(QUEUE_DEPTH) with explicit wrap at QUEUE_DEPTH-1 (non-power-of-two depths supported). Count ranges 0..QUEUE_DEPTH.
- CNT = 1: arbiter degenerates to a pass-through with ID tracking; RR pointer is constant 0.
- Reset asserted mid-transaction: all tracking is discarded. Responses in flight are the system's responsibility; reset of the memory side is concurrent.

Test Plan:
- PRIO_MODE=0, CNT=2, both valid continuously, slave_req.ready=1, responses 1 cycle later → 4 grants to master 0, then master 1 promoted on the 5th issue (STARVE_LIMIT=4), counter cleared.
- PRIO_MODE=1, CNT=3, all valid, always ready → grant order 0,1,2,0,1,2; each master_resp receives exactly its own tagged data.
- QUEUE_DEPTH=2, slave_resp.valid held 0 → third request sees ready=0 while count=2; raising slave_resp.valid with master ready → issue and pop in the same cycle; count stays 2.
- slave_req.ready=0 for 3 cycles with master 1 granted, master 0 raising valid in cycle 2 → slave_req.data stays master 1's and is unchanged until the handshake; master 0 is granted next.
- Issue order 1,0,1 with responses D0,D1,D2 → master 1 gets D0 and D2, master 0 gets D1; backpressure on master_resp[0].ready stalls slave_resp.ready.
- Assert rst with 2 outstanding → next cycle all valids = 0, count = 0, RR pointer = 0; first post-reset request issues normally.

Source files
------------

// File: rtl/prio_mem_arbiter.sv
// N-to-1 memory request arbiter (fixed-priority with starvation promotion, or round-robin)
// with grant locking and in-order response routing through an ID FIFO.
package prio_mem_arbiter_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } mreq_t;

  typedef struct packed {
    logic [31:0] rdata;
  } mtrans_t;
endpackage

module prio_mem_arbiter
  import prio_mem_arbiter_pkg::*;
#(
  parameter int unsigned CNT          = 2,
  parameter int unsigned QUEUE_DEPTH  = 2,
  parameter int unsigned PRIO_MODE    = 0,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT-1:0]    master_req_valid,
  output logic [CNT-1:0]    master_req_ready,
  input  mreq_t [CNT-1:0]   master_req_data,
  output logic [CNT-1:0]    master_resp_valid,
  input  logic [CNT-1:0]    master_resp_ready,
  output mtrans_t [CNT-1:0] master_resp_data,
  output logic              slave_req_valid,
  input  logic              slave_req_ready,
  output mreq_t             slave_req_data,
  input  logic              slave_resp_valid,
  output logic              slave_resp_ready,
  input  mtrans_t           slave_resp_data
);
  localparam int unsigned IW = (CNT > 1) ? $clog2(CNT) : 1;
  localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [IW-1:0] id_mem_q [QUEUE_DEPTH];
  logic [IW-1:0] id_mem_d [QUEUE_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic          lock_q, lock_d;
  logic [IW-1:0] lock_idx_q, lock_idx_d;
  logic [SW-1:0] starve_q [CNT];
  logic [SW-1:0] starve_d [CNT];

  logic          arb_found;
  logic [IW-1:0] arb_idx;
  int unsigned   rr_j;
  logic [IW-1:0] gnt_idx;
  logic          gnt_valid;
  logic          fifo_ne;
  logic [IW-1:0] head;
  logic          resp_hs, req_hs, can_issue;

  // Arbitration: starving masters first in fixed mode, else lowest index; RR scans from pointer
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    rr_j      = 0;
    if (PRIO_MODE == 0) begin
      if (STARVE_LIMIT > 0) begin
        for (int unsigned i = 0; i < CNT; i++) begin
          if (!arb_found && master_req_valid[i] && starve_q[i] == SW'(STARVE_LIMIT)) begin
            arb_found = 1'b1;
            arb_idx   = IW'(i);
          end
        end
      end
      for (int unsigned i = 0; i < CNT; i++) begin
        if (!arb_found && master_req_valid[i]) begin
          arb_found = 1'b1;
          arb_idx   = IW'(i);
        end
      end
    end else begin
      for (int unsigned k = 0; k < CNT; k++) begin
        rr_j = (32'(rr_ptr_q) + k) % CNT;
        if (!arb_found && master_req_valid[IW'(rr_j)]) begin
          arb_found = 1'b1;
          arb_idx   = IW'(rr_j);
        end
      end
    end
  end

  // Pass-through datapath; everything is forced quiet while reset is asserted
  always_comb begin
    gnt_idx           = lock_q ? lock_idx_q : arb_idx;
    gnt_valid         = lock_q ? master_req_valid[lock_idx_q] : arb_found;
    fifo_ne           = (count_q != '0);
    head              = id_mem_q[rd_ptr_q];
    slave_resp_ready  = !rst && fifo_ne && master_resp_ready[head];
    resp_hs           = slave_resp_ready && slave_resp_valid;
    can_issue         = (count_q < CW'(QUEUE_DEPTH)) || resp_hs;
    slave_req_valid   = !rst && gnt_valid && can_issue;
    slave_req_data    = master_req_data[gnt_idx];
    req_hs            = slave_req_valid && slave_req_ready;
    master_req_ready  = '0;
    master_resp_valid = '0;
    if (slave_req_valid && slave_req_ready) master_req_ready[gnt_idx] = 1'b1;
    if (!rst && fifo_ne && slave_resp_valid) master_resp_valid[head] = 1'b1;
    for (int unsigned i = 0; i < CNT; i++) master_resp_data[i] = slave_resp_data;
  end

  // Next-state: ID FIFO, lock, RR pointer and starvation counters
  always_comb begin
    id_mem_d   = id_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    starve_d   = starve_q;
    if (req_hs) begin
      id_mem_d[wr_ptr_q] = gnt_idx;
      wr_ptr_d = (wr_ptr_q == PW'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      rr_ptr_d = (gnt_idx == IW'(CNT - 1)) ? '0 : gnt_idx + 1'b1;
      lock_d   = 1'b0;
      if (PRIO_MODE == 0 && STARVE_LIMIT > 0) begin
        for (int unsigned i = 0; i < CNT; i++) begin
          if (IW'(i) == gnt_idx) starve_d[i] = '0;
          else if (master_req_valid[i] && starve_q[i] != SW'(STARVE_LIMIT))
            starve_d[i] = starve_q[i] + 1'b1;
        end
      end
    end else if (slave_req_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt_idx;
    end
    if (resp_hs) rd_ptr_d = (rd_ptr_q == PW'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({req_hs, resp_hs})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) id_mem_q[i] <= '0;
      for (int unsigned i = 0; i < CNT; i++) starve_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      id_mem_q   <= id_mem_d;
      starve_q   <= starve_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // A response with nothing outstanding has no owner
  a_resp_has_owner: assert property (@(posedge clk) disable iff (rst) slave_resp_valid |-> fifo_ne);

endmodule
